// File: rtl/bcd_gray_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared types, constants and the BCD-to-Gray helper for the
//                BCD/Gray conversion datapath.
//                  bcd_t    - one 4-bit BCD digit
//                  BCD_MAX  - largest legal digit (9)
//                  bin2gray - reflected-binary encoding of a digit
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Each Gray bit is the XOR of a binary bit and its upper neighbour;
    // the MSB passes through unchanged.
    function automatic logic [3:0] bin2gray(input bcd_t b);
        return b ^ (b >> 1);
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/bcd_gray_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_gray_counter_if
//  Description : Control and output-handshake bundle of one BCD/Gray digit.
//                  en, load, load_bcd, dn  - count commands from the source
//                  gray, bcd, carry        - presented code (registered)
//                  out_valid / out_ready   - output handshake
//                  err                     - rejected-load pulse
//                Macro GRAY_UPDOWN_EN adds the dn (count-down) signal.
//                slave  : the counter side
//                master : the driver/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_gray_counter_if;
    import gray_pkg::*;

`ifdef GRAY_UPDOWN_EN
    logic       dn;
`endif
    logic       en;
    logic       load;
    bcd_t       load_bcd;
    logic [3:0] gray;
    bcd_t       bcd;
    logic       carry;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    modport slave (
`ifdef GRAY_UPDOWN_EN
        input  dn,
`endif
        input  en,
        input  load,
        input  load_bcd,
        input  out_ready,
        output gray,
        output bcd,
        output carry,
        output out_valid,
        output err
    );

    modport master (
`ifdef GRAY_UPDOWN_EN
        output dn,
`endif
        output en,
        output load,
        output load_bcd,
        output out_ready,
        input  gray,
        input  bcd,
        input  carry,
        input  out_valid,
        input  err
    );

endinterface : bcd_gray_counter_if
`default_nettype wire

// File: rtl/bcd_gray_counter_bcd2gray.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2gray
//  Description : Combinational 4-bit BCD to Gray encoder.
//                  i_bcd  - BCD digit in
//                  o_gray - Gray code out
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2gray
    import gray_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [3:0] o_gray
);

    assign o_gray = bin2gray(i_bcd);

endmodule : bcd2gray
`default_nettype wire

// File: rtl/bcd_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_gray_counter
//  Description : Registered BCD digit counter (0-9) presenting each count as
//                Gray code through a valid/ready handshake; carry marks a
//                decade wrap for chaining.
//                  clk  - clock, rising edge
//                  rst  - synchronous active-high reset
//                  bus  - bcd_gray_counter_if.slave (commands + output code)
//                Macro GRAY_UPDOWN_EN: adds bus.dn for down counting
//                (0->9 wrap, carry flags the borrow). Undefined: up-only.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_gray_counter
    import gray_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    bcd_gray_counter_if.slave        bus
);

    // Output handshake state: EMPTY = nothing presented, FULL = code pending.
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0] r_state;
    bcd_t       r_count;
    logic [3:0] r_gray;
    logic       r_carry;
    logic       r_err;

    logic       w_free;
    logic       w_down;
    logic       w_load_ok;
    logic       w_load_bad;
    logic       w_step;
    logic       w_accept;
    logic       w_wrap;
    bcd_t       w_step_count;
    bcd_t       w_next_count;
    logic [3:0] w_next_gray;

`ifdef GRAY_UPDOWN_EN
    assign w_down = bus.dn;
`else
    assign w_down = 1'b0;
`endif

    assign w_free     = (r_state == c_ST_EMPTY) || bus.out_ready;
    assign w_accept   = (r_state == c_ST_FULL) && bus.out_ready;
    assign w_load_ok  = bus.load && (bus.load_bcd <= BCD_MAX);
    assign w_load_bad = bus.load && (bus.load_bcd > BCD_MAX);
    // Any load, valid or not, suppresses the step in that cycle.
    assign w_step     = bus.en && !bus.load && w_free;

    // Wrap-around neighbour of the current count in the selected direction.
    always_comb begin
        w_wrap       = 1'b0;
        w_step_count = r_count;
        if (w_down) begin
            if (r_count == 4'd0) begin
                w_step_count = BCD_MAX;
                w_wrap       = 1'b1;
            end else begin
                w_step_count = r_count - 4'd1;
            end
        end else begin
            if (r_count == BCD_MAX) begin
                w_step_count = 4'd0;
                w_wrap       = 1'b1;
            end else begin
                w_step_count = r_count + 4'd1;
            end
        end
    end

    always_comb begin
        w_next_count = r_count;
        if (w_load_ok) begin
            w_next_count = bus.load_bcd;
        end else if (w_step) begin
            w_next_count = w_step_count;
        end
    end

    bcd2gray u_bcd2gray (
        .i_bcd  (w_next_count),
        .o_gray (w_next_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
            r_count <= 4'd0;
            r_gray  <= 4'd0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_load_bad;
            if (w_load_ok) begin
                // A pending unconsumed code is simply overwritten.
                r_count <= w_next_count;
                r_gray  <= w_next_gray;
                r_carry <= 1'b0;
                r_state <= c_ST_FULL;
            end else if (w_step) begin
                r_count <= w_next_count;
                r_gray  <= w_next_gray;
                r_carry <= w_wrap;
                r_state <= c_ST_FULL;
            end else if (w_accept) begin
                r_carry <= 1'b0;
                r_state <= c_ST_EMPTY;
            end
        end
    end

    assign bus.bcd       = r_count;
    assign bus.gray      = r_gray;
    assign bus.carry     = r_carry;
    assign bus.out_valid = (r_state == c_ST_FULL);
    assign bus.err       = r_err;

endmodule : bcd_gray_counter
`default_nettype wire

// File: tb/tb_bcd_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_gray_counter
//  Description : Scoreboard bench for bcd_gray_counter. A reference model
//                of the digit counter pushes expected per-cycle status and
//                expected handshake codes into queues; a monitor on the
//                falling edge pops and compares. Build with GRAY_UPDOWN_EN
//                to exercise down counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_gray_counter;
    import gray_pkg::*;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] gray;
        logic       carry;
    } code_t;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [3:0] bcd;
        logic [3:0] gray;
    } stat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_gray_counter_if bus_if ();

    bcd_gray_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Gray codes of digits 0..9 as listed for the encoder.
    logic [3:0] c_GRAY_TBL [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6,
                                   4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

    code_t codeq[$];
    stat_t statq[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: what the DUT currently presents.
    int m_count = 0;
    bit m_valid = 0;
    bit m_err   = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus, with the model advanced alongside it.
    task automatic cyc(input bit r, input bit e, input bit l, input int lb,
                       input bit d, input bit rd);
        bit    accept;
        int    nxt;
        code_t c;
        @(posedge clk);
        #1;
        rst              = r;
        bus_if.en        = e;
        bus_if.load      = l;
        bus_if.load_bcd  = lb[3:0];
        bus_if.out_ready = rd;
`ifdef GRAY_UPDOWN_EN
        bus_if.dn        = d;
`endif
        statq.push_back('{valid: m_valid, err: m_err,
                          bcd: m_count[3:0], gray: c_GRAY_TBL[m_count]});
        accept = m_valid && rd;
        if (r) begin
            if (m_valid && !accept) void'(codeq.pop_back());
            m_valid = 0; m_err = 0; m_count = 0;
        end else if (l && lb <= 9) begin
            if (m_valid && !accept) void'(codeq.pop_back());
            m_count = lb;
            c = '{bcd: lb[3:0], gray: c_GRAY_TBL[lb], carry: 1'b0};
            codeq.push_back(c);
            m_valid = 1; m_err = 0;
        end else if (l) begin
            m_err = 1;
            if (accept) m_valid = 0;
        end else if (e && (!m_valid || rd)) begin
`ifdef GRAY_UPDOWN_EN
            nxt = d ? (m_count + 9) % 10 : (m_count + 1) % 10;
            c.carry = d ? (m_count == 0) : (m_count == 9);
`else
            nxt = (m_count + 1) % 10;
            c.carry = (m_count == 9);
`endif
            c.bcd  = nxt[3:0];
            c.gray = c_GRAY_TBL[nxt];
            codeq.push_back(c);
            m_count = nxt; m_valid = 1; m_err = 0;
        end else begin
            m_err = 0;
            if (accept) m_valid = 0;
        end
    endtask

    // Monitor: per-cycle status, and the code whenever it is accepted.
    always @(negedge clk) begin
        stat_t s;
        code_t c;
        if (statq.size() > 0) begin
            s = statq.pop_front();
            chk("out_valid", int'(bus_if.out_valid), int'(s.valid));
            chk("err",       int'(bus_if.err),       int'(s.err));
            chk("bcd_hold",  int'(bus_if.bcd),       int'(s.bcd));
            chk("gray_hold", int'(bus_if.gray),      int'(s.gray));
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (codeq.size() == 0) begin
                    chk("unexpected_code", 1, 0);
                end else begin
                    c = codeq.pop_front();
                    chk("code_bcd",   int'(bus_if.bcd),   int'(c.bcd));
                    chk("code_gray",  int'(bus_if.gray),  int'(c.gray));
                    chk("code_carry", int'(bus_if.carry), int'(c.carry));
                end
            end
        end
    end

    initial begin
        bus_if.en        = 1'b0;
        bus_if.load      = 1'b0;
        bus_if.load_bcd  = 4'd0;
        bus_if.out_ready = 1'b0;
`ifdef GRAY_UPDOWN_EN
        bus_if.dn        = 1'b0;
`endif
        // Reset, then a 12-step up run with the consumer always ready.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 1);
        // Valid load, then an out-of-range load.
        cyc(0, 0, 1, 7, 0, 1);
        cyc(0, 0, 1, 12, 0, 0);
        cyc(0, 1, 1, 15, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // Back-pressure: first code then stall for 4 cycles, then release.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1);
        // Reset while FULL holding 5.
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        // Load and en together while FULL and not ready.
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 1, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
`ifdef GRAY_UPDOWN_EN
        // Count down from reset through the 0->9 borrow.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 1);
`endif
        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
        end
        // Drain: nothing should remain unconsumed.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("codeq_drained", codeq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_gray_counter
`default_nettype wire
